pc_sequencer: RTL

//  Owns the fetch-stage PC register and sequences every PC update in the five-stage pipeline.

---
 rtl/pc_sequencer_if.sv | 30 +++
 rtl/pc_sequencer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-PC sequencer bus: hazard/branch side requests on one side,
// registered fetch address and flush strobes on the other.
interface pc_sequencer_if;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        JR;
    logic [31:0] JRTarget;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        FlushIF;
    logic        FlushID;
    logic        FlushEX;
    logic        RedirPending;
    logic        Misalign;

    // Hazard unit / branch logic side
    modport master (
        output Stall, BranchTaken, BranchTarget, Jump, JumpTarget, JR, JRTarget,
        input  PC, PCPlus4, FlushIF, FlushID, FlushEX, RedirPending, Misalign
    );

    // Sequencer side
    modport slave (
        input  Stall, BranchTaken, BranchTarget, Jump, JumpTarget, JR, JRTarget,
        output PC, PCPlus4, FlushIF, FlushID, FlushEX, RedirPending, Misalign
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register and redirect sequencer for a five-stage pipeline.
// Picks between sequential fetch, ID-stage jumps and MEM-stage taken branches,
// parks a redirect while the hazard unit stalls, and drives the flush strobes.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input logic           Clk,
    input logic           Reset,
    pc_sequencer_if.slave bus
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus;
    logic [31:0] pend_target;
    logic        pend_is_branch;
    logic        misalign;

    logic        new_redir;
    logic        new_is_branch;
    logic [31:0] new_target;
    logic [31:0] new_target_aligned;
    logic        take_new;
    logic        latch_new;

    assign pc_plus = pc + PC_INC;

    // Pick the oldest requesting instruction's target: MEM branch, then JR, then J
    always_comb begin
        new_redir     = bus.BranchTaken | bus.JR | bus.Jump;
        new_is_branch = bus.BranchTaken;
        if (bus.BranchTaken)
            new_target = bus.BranchTarget;
        else if (bus.JR)
            new_target = bus.JRTarget;
        else
            new_target = bus.JumpTarget;
        new_target_aligned = {new_target[31:2], 2'b00};
    end

    // Decide whether a new request is accepted; while parked only a branch may
    // displace a parked jump, since the branch belongs to an older instruction
    always_comb begin
        if (state == ST_PEND)
            take_new = bus.BranchTaken & ~pend_is_branch;
        else
            take_new = new_redir;
    end

    // Next-state and next-PC selection
    always_comb begin
        state_next = state;
        pc_next    = pc;
        latch_new  = 1'b0;
        case (state)
            ST_RUN, ST_HOLD: begin
                if (!bus.Stall) begin
                    state_next = ST_RUN;
                    pc_next    = take_new ? new_target_aligned : pc_plus;
                end else if (take_new) begin
                    state_next = ST_PEND;
                    latch_new  = 1'b1;
                end else begin
                    state_next = ST_HOLD;
                end
            end
            ST_PEND: begin
                if (!bus.Stall) begin
                    state_next = ST_RUN;
                    pc_next    = take_new ? new_target_aligned : pend_target;
                end else if (take_new) begin
                    latch_new  = 1'b1;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Control state, PC and misalignment pulse; reset aborts any parked redirect
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state          <= ST_RUN;
            pc             <= RESET_PC;
            pend_is_branch <= 1'b0;
            misalign       <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            misalign <= take_new & (new_target[1:0] != 2'b00);
            if (latch_new)
                pend_is_branch <= new_is_branch;
            else if (state_next != ST_PEND)
                pend_is_branch <= 1'b0;
        end
    end

    // Parked target; only meaningful while pend state is active, so no reset
    always_ff @(posedge Clk) begin
        if (latch_new)
            pend_target <= new_target_aligned;
    end

    // Outputs: flushes fire in the cycle a redirect is accepted, IF every parked cycle
    always_comb begin
        bus.PC           = pc;
        bus.PCPlus4      = pc_plus;
        bus.RedirPending = (state == ST_PEND);
        bus.FlushIF      = take_new | (state == ST_PEND);
        bus.FlushID      = take_new & new_is_branch;
        bus.FlushEX      = take_new & new_is_branch;
        bus.Misalign     = misalign;
    end

endmodule
